// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_add_sub.sv
// One-bit full adder / full subtractor cell; cb is carry (add) or borrow (sub).
module full_add_sub
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cb_in,
  input  logic mode,
  output logic s,
  output logic cb_out
);

  assign s = a ^ b ^ cb_in;

  always_comb begin
    cb_out = 1'b0;
    if (mode == MODE_SUB) begin
      // Borrow when a < b + borrow_in.
      cb_out = (~a & b) | (~(a ^ b) & cb_in);
    end else begin
      cb_out = (a & b) | (cb_in & (a ^ b));
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, WIDTH cycles per operation.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cb_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            op_mode;
  logic [CntW-1:0] cnt;
  logic            cb;
  logic            s_bit;
  logic            cb_next;
  logic            last_bit;

  full_add_sub u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cb_in  (cb),
    .mode   (op_mode),
    .s      (s_bit),
    .cb_out (cb_next)
  );

  assign last_bit = (cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      op_mode  <= MODE_ADD;
      cnt      <= '0;
      cb       <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      cb_o     <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      // done_o is the registered image of the DONE state.
      done_o <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            op_mode <= mode_i;
            cnt     <= '0;
            cb      <= 1'b0;
            busy_o  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // Sum bits shift in at the top of a_sh, which holds the result after WIDTH steps.
          a_sh <= {s_bit, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cb   <= cb_next;
          if (last_bit) begin
            result_o <= {s_bit, a_sh[WIDTH-1:1]};
            cb_o     <= cb_next;
            // Signed overflow: carry/borrow into the MSB differs from the one out of it.
            ovf_o    <= cb ^ cb_next;
            busy_o   <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
